dac_spi_frame_receiver: RTL and testbench



---
 rtl/dac_spi_frame_receiver.sv | 170 +++++++++++++++++
 tb/tb_dac_spi_frame_receiver.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_spi_frame_receiver.sv
// Oversampling receiver for a multi-lane DAC serial bus: recovers one word per
// lane per CS_N frame, MSB first, and flags frames with the wrong bit count.
module dac_spi_frame_receiver #(
  parameter int NUM_CH      = 4,
  parameter int WORD_BITS   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        spi_sck,
  input  logic [NUM_CH-1:0]           spi_cs_n,
  input  logic [NUM_CH-1:0]           spi_sdo,
  input  logic                        error_clear,
  output logic [NUM_CH*WORD_BITS-1:0] data_out,
  output logic [NUM_CH-1:0]           data_valid,
  output logic [NUM_CH-1:0]           frame_error,
  output logic [NUM_CH-1:0]           error_sticky,
  output logic [31:0]                 frame_count
);

  localparam int CNT_W   = $clog2(WORD_BITS + 2);
  localparam int FLUSH_W = $clog2(SYNC_STAGES + 2);
  localparam logic [CNT_W-1:0]   CNT_FULL   = CNT_W'(WORD_BITS);
  localparam logic [CNT_W-1:0]   CNT_MAX    = CNT_W'(WORD_BITS + 1);
  localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(SYNC_STAGES + 1);

  // Synchronizer chains; stage 0 samples the pins.
  logic [SYNC_STAGES-1:0]        sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES*NUM_CH-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES*NUM_CH-1:0] sdo_sync_q, sdo_sync_d;

  logic              s_sck;
  logic [NUM_CH-1:0] s_cs_n, s_sdo;
  logic              p_sck_q, p_sck_d;
  logic [NUM_CH-1:0] p_cs_n_q, p_cs_n_d;

  // Edge flags are registered together with aligned copies of cs_n/sdo.
  logic              sck_rise_q, sck_rise_d;
  logic [NUM_CH-1:0] cs_rise_q, cs_rise_d;
  logic [NUM_CH-1:0] cs_fall_q, cs_fall_d;
  logic [NUM_CH-1:0] cs_dly_q, cs_dly_d;
  logic [NUM_CH-1:0] sdo_dly_q, sdo_dly_d;

  logic [FLUSH_W-1:0] flush_q, flush_d;
  logic               flushed;

  logic [WORD_BITS-1:0] shift_q [NUM_CH];
  logic [WORD_BITS-1:0] shift_d [NUM_CH];
  logic [CNT_W-1:0]     cnt_q   [NUM_CH];
  logic [CNT_W-1:0]     cnt_d   [NUM_CH];
  logic [NUM_CH-1:0]    armed_q, armed_d;

  logic [NUM_CH*WORD_BITS-1:0] data_q, data_d;
  logic [NUM_CH-1:0]           valid_q, valid_d;
  logic [NUM_CH-1:0]           err_q, err_d;
  logic [NUM_CH-1:0]           sticky_q, sticky_d;
  logic [31:0]                 count_q, count_d;
  logic [31:0]                 count_inc;

  assign s_sck   = sck_sync_q[SYNC_STAGES-1];
  assign s_cs_n  = cs_sync_q[SYNC_STAGES*NUM_CH-1 -: NUM_CH];
  assign s_sdo   = sdo_sync_q[SYNC_STAGES*NUM_CH-1 -: NUM_CH];
  assign flushed = (flush_q == FLUSH_LAST);

  always_comb begin
    sck_sync_d = {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
    cs_sync_d  = {cs_sync_q[(SYNC_STAGES-1)*NUM_CH-1:0], spi_cs_n};
    sdo_sync_d = {sdo_sync_q[(SYNC_STAGES-1)*NUM_CH-1:0], spi_sdo};
    p_sck_d    = s_sck;
    p_cs_n_d   = s_cs_n;
    sck_rise_d = s_sck & ~p_sck_q;
    cs_rise_d  = s_cs_n & ~p_cs_n_q;
    cs_fall_d  = ~s_cs_n & p_cs_n_q;
    cs_dly_d   = s_cs_n;
    sdo_dly_d  = s_sdo;
    flush_d    = flushed ? flush_q : flush_q + FLUSH_W'(1);
  end

  // Arming waits for the synchronizers to flush their reset values, so a
  // frame already in progress when reset drops is never mistaken for idle.
  always_comb begin
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    armed_d   = armed_q;
    data_d    = data_q;
    valid_d   = '0;
    err_d     = '0;
    count_inc = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (flushed && cs_dly_q[i]) armed_d[i] = 1'b1;
      if (armed_q[i]) begin
        if (cs_fall_q[i]) begin
          shift_d[i] = '0;
          cnt_d[i]   = '0;
        end
        if (sck_rise_q && !cs_dly_q[i]) begin
          shift_d[i] = {shift_d[i][WORD_BITS-2:0], sdo_dly_q[i]};
          if (cnt_d[i] != CNT_MAX) cnt_d[i] = cnt_d[i] + CNT_W'(1);
        end
        if (cs_rise_q[i]) begin
          if (cnt_q[i] == CNT_FULL) begin
            valid_d[i] = 1'b1;
            data_d[i*WORD_BITS +: WORD_BITS] = shift_q[i];
          end else begin
            err_d[i] = 1'b1;
          end
        end
      end
      count_inc = count_inc + {31'b0, valid_d[i]};
    end
    count_d  = count_q + count_inc;
    // A new error on a lane overrides a simultaneous clear.
    sticky_d = (sticky_q & ~{NUM_CH{error_clear}}) | err_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sck_sync_q <= '0;
      cs_sync_q  <= '1;
      sdo_sync_q <= '0;
      p_sck_q    <= 1'b0;
      p_cs_n_q   <= '1;
      sck_rise_q <= 1'b0;
      cs_rise_q  <= '0;
      cs_fall_q  <= '0;
      cs_dly_q   <= '1;
      sdo_dly_q  <= '0;
      flush_q    <= '0;
      armed_q    <= '0;
      data_q     <= '0;
      valid_q    <= '0;
      err_q      <= '0;
      sticky_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        shift_q[i] <= '0;
        cnt_q[i]   <= '0;
      end
    end else begin
      sck_sync_q <= sck_sync_d;
      cs_sync_q  <= cs_sync_d;
      sdo_sync_q <= sdo_sync_d;
      p_sck_q    <= p_sck_d;
      p_cs_n_q   <= p_cs_n_d;
      sck_rise_q <= sck_rise_d;
      cs_rise_q  <= cs_rise_d;
      cs_fall_q  <= cs_fall_d;
      cs_dly_q   <= cs_dly_d;
      sdo_dly_q  <= sdo_dly_d;
      flush_q    <= flush_d;
      armed_q    <= armed_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      sticky_q   <= sticky_d;
      count_q    <= count_d;
      for (int i = 0; i < NUM_CH; i++) begin
        shift_q[i] <= shift_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  assign data_out     = data_q;
  assign data_valid   = valid_q;
  assign frame_error  = err_q;
  assign error_sticky = sticky_q;
  assign frame_count  = count_q;

endmodule

// File: tb/tb_dac_spi_frame_receiver.sv
// Bench for dac_spi_frame_receiver: drives 4-lane serial frames and checks the
// recovered words, error pulses and frame count against a word-level model.
`timescale 1ns/1ps
module tb_dac_spi_frame_receiver;

  localparam int NUM_CH = 4;
  localparam int WB     = 16;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 spi_sck;
  logic [NUM_CH-1:0]    spi_cs_n;
  logic [NUM_CH-1:0]    spi_sdo;
  logic                 error_clear;
  logic [NUM_CH*WB-1:0] data_out;
  logic [NUM_CH-1:0]    data_valid;
  logic [NUM_CH-1:0]    frame_error;
  logic [NUM_CH-1:0]    error_sticky;
  logic [31:0]          frame_count;

  dac_spi_frame_receiver #(.NUM_CH(NUM_CH), .WORD_BITS(WB), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .spi_sck(spi_sck), .spi_cs_n(spi_cs_n),
    .spi_sdo(spi_sdo), .error_clear(error_clear), .data_out(data_out),
    .data_valid(data_valid), .frame_error(frame_error),
    .error_sticky(error_sticky), .frame_count(frame_count)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: words expected per lane, last good word, counters.
  logic [WB-1:0] exp_q [NUM_CH][$];
  logic [WB-1:0] exp_data [NUM_CH];
  logic [31:0]   exp_count;
  logic [NUM_CH-1:0] exp_sticky;
  int            exp_err [NUM_CH];

  // Observed pulses
  logic [WB-1:0] got_q [NUM_CH][$];
  int            valid_seen [NUM_CH];
  int            err_seen [NUM_CH];

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (data_valid[i] === 1'b1) begin
        got_q[i].push_back(data_out[i*WB +: WB]);
        valid_seen[i]++;
      end
      if (frame_error[i] === 1'b1) err_seen[i]++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  function automatic void model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      exp_q[i].delete();
      exp_data[i] = '0;
      exp_err[i]  = 0;
    end
    exp_count  = '0;
    exp_sticky = '0;
  endfunction

  // A lane frame is good exactly when it carried WB bits.
  function automatic void model_frame(input logic [NUM_CH-1:0] mask, input int nbits,
                                      input logic [NUM_CH*WB-1:0] words);
    for (int i = 0; i < NUM_CH; i++) begin
      if (mask[i]) begin
        if (nbits == WB) begin
          exp_q[i].push_back(words[i*WB +: WB]);
          exp_data[i] = words[i*WB +: WB];
          exp_count   = exp_count + 32'd1;
        end else begin
          exp_err[i]++;
          exp_sticky[i] = 1'b1;
        end
      end
    end
  endfunction

  task automatic clear_logs();
    for (int i = 0; i < NUM_CH; i++) begin
      got_q[i].delete();
      exp_q[i].delete();
      valid_seen[i] = 0;
      err_seen[i]   = 0;
      exp_err[i]    = 0;
    end
  endtask

  // Driver: lowers CS_N on masked lanes and clocks nbits bits, MSB first.
  // CS_N is left low; cs_release ends the frame.
  task automatic frame_body(input logic [NUM_CH-1:0] mask, input int nbits,
                            input logic [NUM_CH*WB-1:0] words, input int half);
    logic [NUM_CH*WB-1:0] w;
    w = words;
    @(negedge clk);
    spi_cs_n = spi_cs_n & ~mask;
    for (int b = 0; b < nbits; b++) begin
      for (int l = 0; l < NUM_CH; l++) begin
        if (mask[l] && b < WB) spi_sdo[l] = w[l*WB + WB - 1 - b];
        else                   spi_sdo[l] = 1'($urandom_range(0, 1));
      end
      repeat (half) @(negedge clk);
      spi_sck = 1'b1;
      repeat (half) @(negedge clk);
      spi_sck = 1'b0;
    end
    repeat (half) @(negedge clk);
  endtask

  task automatic cs_release(input logic [NUM_CH-1:0] mask);
    @(negedge clk);
    spi_cs_n = spi_cs_n | mask;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_frame(input logic [NUM_CH-1:0] mask, input int nbits,
                            input logic [NUM_CH*WB-1:0] words, input int half);
    frame_body(mask, nbits, words, half);
    cs_release(mask);
    model_frame(mask, nbits, words);
  endtask

  task automatic test_reset();
    reset = 1'b1; spi_sck = 1'b0; spi_cs_n = '1; spi_sdo = '0; error_clear = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    model_reset();
    clear_logs();
    n_checks++; if (data_out !== '0) $display("FAIL reset_data_out: got %h want 0", data_out); else n_pass++;
    n_checks++; if (data_valid !== '0) $display("FAIL reset_data_valid: got %b want 0", data_valid); else n_pass++;
    n_checks++; if (frame_error !== '0) $display("FAIL reset_frame_error: got %b want 0", frame_error); else n_pass++;
    n_checks++; if (error_sticky !== '0) $display("FAIL reset_sticky: got %b want 0", error_sticky); else n_pass++;
    n_checks++; if (frame_count !== 32'd0) $display("FAIL reset_count: got %0d want 0", frame_count); else n_pass++;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_single_lane();
    int k;
    logic [NUM_CH*WB-1:0] w;
    clear_logs();
    w = '0;
    w[WB-1:0] = 16'hA5C3;
    frame_body(4'b0001, WB, w, 2);
    model_frame(4'b0001, WB, w);
    @(negedge clk);
    spi_cs_n[0] = 1'b1;
    k = 0;
    while (k < 12) begin
      @(posedge clk); #1;
      k++;
      if (data_valid !== '0) break;
    end
    n_checks++; if (k != 4) $display("FAIL single_latency: got %0d cycles want 4", k); else n_pass++;
    n_checks++; if (data_valid !== 4'b0001) $display("FAIL single_valid: got %b want 0001", data_valid); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (data_valid !== 4'b0000) $display("FAIL single_valid_width: got %b want 0000", data_valid); else n_pass++;
    repeat (6) @(negedge clk);
    n_checks++; if (data_out[WB-1:0] !== exp_data[0]) $display("FAIL single_data: got %h want %h", data_out[WB-1:0], exp_data[0]); else n_pass++;
    n_checks++; if (frame_count !== exp_count) $display("FAIL single_count: got %0d want %0d", frame_count, exp_count); else n_pass++;
    n_checks++; if (error_sticky !== exp_sticky || err_seen[0] != 0) $display("FAIL single_errors: got sticky %b pulses %0d want %b 0", error_sticky, err_seen[0], exp_sticky); else n_pass++;
  endtask

  task automatic test_all_lanes();
    int k;
    logic [NUM_CH*WB-1:0] w;
    clear_logs();
    w = {16'h1234, 16'hFFFF, 16'h0001, 16'h8000};
    frame_body(4'b1111, WB, w, 2);
    model_frame(4'b1111, WB, w);
    @(negedge clk);
    spi_cs_n = '1;
    k = 0;
    while (k < 12) begin
      @(posedge clk); #1;
      k++;
      if (data_valid !== '0) break;
    end
    n_checks++; if (data_valid !== 4'b1111) $display("FAIL all_valid_same_cycle: got %b want 1111", data_valid); else n_pass++;
    repeat (6) @(negedge clk);
    for (int i = 0; i < NUM_CH; i++) begin
      n_checks++;
      if (data_out[i*WB +: WB] !== exp_data[i]) $display("FAIL all_data_lane%0d: got %h want %h", i, data_out[i*WB +: WB], exp_data[i]);
      else n_pass++;
    end
    n_checks++; if (frame_count !== exp_count) $display("FAIL all_count: got %0d want %0d", frame_count, exp_count); else n_pass++;
  endtask

  task automatic test_errors();
    logic [NUM_CH*WB-1:0] w;
    clear_logs();
    w = {$urandom, $urandom};
    send_frame(4'b0100, WB - 1, w, 2);
    send_frame(4'b0100, WB + 1, w, 3);
    repeat (4) @(negedge clk);
    n_checks++; if (err_seen[2] != exp_err[2]) $display("FAIL err_pulses: got %0d want %0d", err_seen[2], exp_err[2]); else n_pass++;
    n_checks++; if (error_sticky !== exp_sticky) $display("FAIL err_sticky: got %b want %b", error_sticky, exp_sticky); else n_pass++;
    n_checks++; if (data_out[2*WB +: WB] !== exp_data[2]) $display("FAIL err_data_hold: got %h want %h", data_out[2*WB +: WB], exp_data[2]); else n_pass++;
    n_checks++; if (frame_count !== exp_count) $display("FAIL err_count: got %0d want %0d", frame_count, exp_count); else n_pass++;
    n_checks++; if (valid_seen[2] != 0) $display("FAIL err_no_valid: got %0d want 0", valid_seen[2]); else n_pass++;
    @(negedge clk); error_clear = 1'b1;
    @(negedge clk); error_clear = 1'b0;
    exp_sticky = '0;
    n_checks++; if (error_sticky !== exp_sticky) $display("FAIL err_clear: got %b want %b", error_sticky, exp_sticky); else n_pass++;
    // Lane 3 gets a sticky error, then a lane 2 error lands with a clear.
    send_frame(4'b1000, 3, w, 2);
    frame_body(4'b0100, 10, w, 2);
    model_frame(4'b0100, 10, w);
    @(negedge clk); spi_cs_n[2] = 1'b1;
    repeat (3) @(negedge clk);
    error_clear = 1'b1;
    @(negedge clk); error_clear = 1'b0;
    exp_sticky = 4'b0100;
    n_checks++; if (error_sticky !== exp_sticky) $display("FAIL err_clear_collision: got %b want %b", error_sticky, exp_sticky); else n_pass++;
    repeat (4) @(negedge clk);
    n_checks++; if (err_seen[2] != exp_err[2] || err_seen[3] != exp_err[3]) $display("FAIL err_collision_pulses: got %0d/%0d want %0d/%0d", err_seen[2], err_seen[3], exp_err[2], exp_err[3]); else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    logic [NUM_CH*WB-1:0] w;
    clear_logs();
    w = {$urandom, $urandom};
    frame_body(4'b0010, 8, w, 2);
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk); reset = 1'b0;
    model_reset();
    n_checks++; if (data_out !== '0 || frame_count !== 32'd0) $display("FAIL midrst_state: got data %h count %0d want 0 0", data_out, frame_count); else n_pass++;
    frame_body(4'b0010, 8, w, 2);
    cs_release(4'b0010);
    repeat (4) @(negedge clk);
    n_checks++; if (valid_seen[1] != 0 || err_seen[1] != 0) $display("FAIL midrst_silent: got valid %0d err %0d want 0 0", valid_seen[1], err_seen[1]); else n_pass++;
    w = '0;
    w[WB +: WB] = 16'h00FF;
    send_frame(4'b0010, WB, w, 2);
    repeat (4) @(negedge clk);
    n_checks++; if (valid_seen[1] != 1) $display("FAIL midrst_next_valid: got %0d want 1", valid_seen[1]); else n_pass++;
    n_checks++; if (data_out[WB +: WB] !== exp_data[1]) $display("FAIL midrst_next_data: got %h want %h", data_out[WB +: WB], exp_data[1]); else n_pass++;
    n_checks++; if (frame_count !== exp_count) $display("FAIL midrst_count: got %0d want %0d", frame_count, exp_count); else n_pass++;
  endtask

  task automatic test_random_loopback();
    logic [NUM_CH*WB-1:0] w;
    logic [NUM_CH-1:0] mask;
    logic [WB-1:0] g, e;
    int r, nbits;
    clear_logs();
    for (int f = 0; f < 100; f++) begin
      mask = 4'($urandom_range(1, 15));
      w    = {$urandom, $urandom};
      r    = $urandom_range(0, 9);
      nbits = (r < 7) ? WB : (r == 7) ? WB - 1 : (r == 8) ? WB + 1 : $urandom_range(0, WB + 3);
      send_frame(mask, nbits, w, $urandom_range(2, 3));
    end
    repeat (6) @(negedge clk);
    for (int i = 0; i < NUM_CH; i++) begin
      n_checks++;
      if (got_q[i].size() != exp_q[i].size()) $display("FAIL rand_words_lane%0d: got %0d words want %0d", i, got_q[i].size(), exp_q[i].size());
      else n_pass++;
      while (got_q[i].size() > 0 && exp_q[i].size() > 0) begin
        g = got_q[i].pop_front();
        e = exp_q[i].pop_front();
        n_checks++;
        if (g !== e) $display("FAIL rand_word_lane%0d: got %h want %h", i, g, e);
        else n_pass++;
      end
      n_checks++;
      if (err_seen[i] != exp_err[i]) $display("FAIL rand_err_lane%0d: got %0d want %0d", i, err_seen[i], exp_err[i]);
      else n_pass++;
      n_checks++;
      if (data_out[i*WB +: WB] !== exp_data[i]) $display("FAIL rand_data_lane%0d: got %h want %h", i, data_out[i*WB +: WB], exp_data[i]);
      else n_pass++;
    end
    n_checks++; if (frame_count !== exp_count) $display("FAIL rand_count: got %0d want %0d", frame_count, exp_count); else n_pass++;
    n_checks++; if (error_sticky !== exp_sticky) $display("FAIL rand_sticky: got %b want %b", error_sticky, exp_sticky); else n_pass++;
  endtask

  task automatic test_count_wrap();
    logic [NUM_CH*WB-1:0] w;
    clear_logs();
    @(negedge clk);
    force dut.count_q = 32'hFFFF_FFFE;
    @(negedge clk);
    release dut.count_q;
    exp_count = 32'hFFFF_FFFE;
    w = {$urandom, $urandom};
    send_frame(4'b0001, WB, w, 2);
    repeat (4) @(negedge clk);
    n_checks++; if (frame_count !== exp_count) $display("FAIL wrap_first: got %h want %h", frame_count, exp_count); else n_pass++;
    send_frame(4'b1000, WB, w, 2);
    repeat (4) @(negedge clk);
    n_checks++; if (frame_count !== exp_count) $display("FAIL wrap_second: got %h want %h", frame_count, exp_count); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_lane();
    test_all_lanes();
    test_errors();
    test_reset_mid_frame();
    test_random_loopback();
    test_count_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
